// File: rtl/axis_framer_pkg.sv
// Framing constants, framer state enum and escape-class test.
// Shared by the framer and the deframer.
package axis_framer_pkg;

  localparam logic [7:0] START_BYTE  = 8'h7D;
  localparam logic [7:0] STOP_BYTE   = 8'h7E;
  localparam logic [7:0] ESCAPE_BYTE = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ESC,
    ST_STOP
  } fr_state_t;

  function automatic logic needs_esc(
    input logic [7:0] b
  );
    return (b == ESCAPE_BYTE) ||
           (b == START_BYTE)  ||
           (b == STOP_BYTE);
  endfunction

endpackage

// File: rtl/axis_framer_if.sv
// Byte-wide AXI4-Stream bundle: tvalid, tready, tdata[7:0], tlast.
// master drives valid/data/last, slave drives ready.
interface axis_framer_if;

  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_framer.sv
// AXI4-Stream packet to self-delimiting byte stream framer.
// Ports: aclk, areset (async, active-high), target (slave
// payload in), initiator (master framed bytes out).
module axis_framer
  import axis_framer_pkg::*;
#(
  parameter bit TLAST_ON_STOP = 1'b1
) (
  input  logic          aclk,
  input  logic          areset,
  axis_framer_if.slave  target,
  axis_framer_if.master initiator
);

  fr_state_t  state;
  logic       vld;
  logic [7:0] dat;
  logic       lst;
  logic       advance;
  logic       esc;

  assign advance = !vld || initiator.tready;
  assign esc     = needs_esc(target.tdata);

  // Escaped bytes stay on the target bus until
  // the ESC cycle consumes them.
  assign target.tready = advance &&
    ((state == ST_DATA && !esc) ||
     (state == ST_ESC));

  assign initiator.tvalid = vld;
  assign initiator.tdata  = dat;
  assign initiator.tlast  = lst;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
      vld   <= 1'b0;
      dat   <= 8'h00;
      lst   <= 1'b0;
    end else if (advance) begin
      vld <= 1'b0;
      lst <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (target.tvalid) begin
            vld   <= 1'b1;
            dat   <= START_BYTE;
            state <= ST_DATA;
          end
        end
        (state == ST_DATA): begin
          if (target.tvalid) begin
            vld <= 1'b1;
            if (esc) begin
              dat   <= ESCAPE_BYTE;
              state <= ST_ESC;
            end else begin
              dat <= target.tdata;
              if (target.tlast)
                state <= ST_STOP;
            end
          end
        end
        (state == ST_ESC): begin
          if (target.tvalid) begin
            vld   <= 1'b1;
            dat   <= target.tdata;
            state <= target.tlast ? ST_STOP
                                  : ST_DATA;
          end
        end
        (state == ST_STOP): begin
          vld   <= 1'b1;
          dat   <= STOP_BYTE;
          lst   <= TLAST_ON_STOP;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
